// File: rtl/lsu_mem_master.sv
// LSU-side sram initiator: one load/store in flight, lane alignment, load extension, timeout.
// Latency: accept c0, ren/wen c1, response the cycle after mem_valid; req_ready low outside IDLE.
module lsu_mem_master #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lane_q, lane_d;
  logic [1:0]       size_q, size_d;
  logic             sgn_q, sgn_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             mem_ren_q, mem_ren_d;
  logic             mem_wen_q, mem_wen_d;
  logic [7:0]       mem_wmask_q, mem_wmask_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  logic             illegal;
  logic             expire;
  logic [3:0]       st_mask;
  logic [31:0]      st_data;
  logic [31:0]      rd_shift;
  logic [31:0]      rd_ext;

  assign req_ready = rst & (state_q == IDLE);
  assign expire    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    illegal = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    st_mask = 4'hF;
    st_data = req_wdata;
    case (req_size)
      2'b00: begin
        st_mask = 4'b0001 << req_addr[1:0];
        st_data = {24'b0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
      end
      2'b01: begin
        st_mask = 4'b0011 << req_addr[1:0];
        st_data = {16'b0, req_wdata[15:0]} << {req_addr[1:0], 3'b000};
      end
      default: ;
    endcase
  end

  // Load lane is picked from the address captured at accept, not the live request bus.
  always_comb begin
    rd_shift = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   rd_ext = {{24{sgn_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = {{16{sgn_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_ren_d   = mem_ren_q;
    mem_wen_d   = mem_wen_q;
    mem_wmask_d = mem_wmask_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          lane_d = req_addr[1:0];
          size_d = req_size;
          sgn_d  = req_signed;
          cnt_d  = '0;
          if (illegal) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'b0;
          end else if (req_store) begin
            state_d     = WR_WAIT;
            mem_wen_d   = 1'b1;
            mem_wmask_d = {4'b0, st_mask};
            mem_wdata_d = st_data;
            mem_addr_d  = {req_addr[31:2], 2'b00};
          end else begin
            state_d    = RD_WAIT;
            mem_ren_d  = 1'b1;
            mem_addr_d = {req_addr[31:2], 2'b00};
          end
        end
      end
      RD_WAIT: begin
        if (mem_valid || expire) begin
          state_d     = RESP;
          mem_ren_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !mem_valid;
          rsp_rdata_d = mem_valid ? rd_ext : 32'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_WAIT: begin
        if (mem_valid || expire) begin
          state_d     = RESP;
          mem_wen_d   = 1'b0;
          mem_wmask_d = 8'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !mem_valid;
          rsp_rdata_d = 32'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lane_q      <= 2'b0;
      size_q      <= 2'b0;
      sgn_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'b0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_wmask_q <= 8'b0;
      mem_addr_q  <= 32'b0;
      mem_wdata_q <= 32'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_wmask_q <= mem_wmask_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed cases then random load/store traffic against a
// byte-addressed memory model; the bench itself plays the sram with a chosen response delay.
module tb_lsu_mem_master;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'b0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
  logic        rsp_valid, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        mem_ren, mem_wen;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'b0;
  logic        mem_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] bmem [16];

  lsu_mem_master #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [3:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) bmem[{a[3:2], 2'b00} + 4'(i)] = v[8*i +: 8];
  endtask

  function automatic logic [31:0] word_at(input logic [3:0] a);
    logic [3:0] b;
    b = {a[3:2], 2'b00};
    return {bmem[b + 4'd3], bmem[b + 4'd2], bmem[b + 4'd1], bmem[b]};
  endfunction

  // Reference load: gather n bytes little-endian from the byte memory, then extend.
  function automatic logic [31:0] model_load(input logic [3:0] a, input logic [1:0] sz, input logic sg);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'b0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = bmem[a + 4'(i)];
    if (sg && n < 4 && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_txn(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int d, input int hold);
    int n;
    int ln;
    logic bad, done, eerr;
    logic [7:0] emask;
    logic [31:0] ewd, erd;
    n = 1 << sz;
    ln = int'(addr[1:0]);
    bad = (sz == 2'b11) || ((ln % n) != 0);
    emask = 8'b0;
    ewd = 32'b0;
    if (!bad) for (int i = 0; i < n; i++) begin
      emask[ln + i] = 1'b1;
      ewd[8*(ln + i) +: 8] = wd[8*i +: 8];
    end
    erd = bad ? 32'b0 : model_load(addr[3:0], sz, sg);

    chk1("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_signed = 1'($urandom);
    done = 1'b0;
    eerr = 1'b1;
    if (bad) begin
      chk1("bad_no_ren", mem_ren, 1'b0);
      chk1("bad_no_wen", mem_wen, 1'b0);
    end else begin
      for (int c = 0; c < T && !done; c++) begin
        chk1("wait_ren", mem_ren, !st);
        chk1("wait_wen", mem_wen, st);
        chk32("wait_addr", mem_addr, {addr[31:2], 2'b00});
        if (st) begin
          chk32("wait_wmask", {24'b0, mem_wmask}, {24'b0, emask});
          chk32("wait_wdata", mem_wdata, ewd);
        end
        if (c == d) begin
          mem_valid = 1'b1;
          mem_rdata = st ? $urandom : word_at(addr[3:0]);
          done = 1'b1;
        end
        step();
        mem_valid = 1'b0;
        mem_rdata = $urandom;
      end
      eerr = !done;
      chk1("done_ren", mem_ren, 1'b0);
      chk1("done_wen", mem_wen, 1'b0);
      if (st) chk32("done_wmask", {24'b0, mem_wmask}, 32'b0);
      if (st && done) for (int i = 0; i < 8; i++) if (emask[i]) bmem[{addr[3:2], 2'(i)}] = ewd[8*i +: 8];
    end
    if (!done || st) erd = 32'b0;
    chk1("rsp_valid", rsp_valid, 1'b1);
    chk1("rsp_err", rsp_err, eerr);
    chk32("rsp_rdata", rsp_rdata, erd);
    for (int h = 0; h < hold; h++) begin
      mem_valid = 1'($urandom);
      step();
      chk1("hold_valid", rsp_valid, 1'b1);
      chk1("hold_err", rsp_err, eerr);
      chk32("hold_rdata", rsp_rdata, erd);
      chk1("hold_req_ready", req_ready, 1'b0);
      chk1("hold_no_ren", mem_ren | mem_wen, 1'b0);
    end
    mem_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk1("post_rsp_valid", rsp_valid, 1'b0);
    chk1("post_rsp_err", rsp_err, 1'b0);
    chk32("post_rsp_rdata", rsp_rdata, 32'b0);
    chk1("post_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) bmem[i] = 8'($urandom);
    #1;
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_ren", mem_ren, 1'b0);
    chk1("rst_wen", mem_wen, 1'b0);
    chk32("rst_rdata", rsp_rdata, 32'b0);
    chk32("rst_wmask", {24'b0, mem_wmask}, 32'b0);
    chk32("rst_addr", mem_addr, 32'b0);
    chk32("rst_wdata", mem_wdata, 32'b0);
    step();
    rst = 1'b1;
    step();

    set_word(4'h0, 32'hDEADBEEF);
    do_txn(1'b0, 2'b10, 1'b0, 32'h80000010, 32'h0, 1, 0);
    set_word(4'h0, 32'h80FF1234);
    do_txn(1'b0, 2'b00, 1'b1, 32'h80000003, 32'h0, 1, 0);
    chk32("t2_signed_byte", model_load(4'h3, 2'b00, 1'b1), 32'hFFFFFF80);
    do_txn(1'b0, 2'b00, 1'b0, 32'h80000003, 32'h0, 1, 0);
    do_txn(1'b1, 2'b01, 1'b0, 32'h80000002, 32'h0000ABCD, 1, 1);
    do_txn(1'b0, 2'b10, 1'b0, 32'h80000001, 32'h0, 0, 1);
    do_txn(1'b0, 2'b10, 1'b0, 32'h80000004, 32'h0, 100, 3);
    do_txn(1'b1, 2'b10, 1'b0, 32'h80000008, 32'h12345678, T - 1, 0);

    chk1("t6_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_addr = 32'h80000004;
    step();
    req_valid = 1'b0;
    chk1("t6_ren_on", mem_ren, 1'b1);
    step();
    rst = 1'b0;
    #1;
    chk1("t6_ren_drop", mem_ren, 1'b0);
    chk1("t6_no_rsp", rsp_valid, 1'b0);
    chk1("t6_req_ready_low", req_ready, 1'b0);
    step();
    rst = 1'b1;
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    step();
    chk1("t6_still_no_rsp", rsp_valid, 1'b0);
    chk1("t6_no_ren", mem_ren, 1'b0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h80000004, 32'h0, 1, 0);

    for (int k = 0; k < 200; k++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_txn(1'($urandom), sz, 1'($urandom), 32'h80000000 | 32'($urandom_range(0, 15)),
             $urandom, $urandom_range(0, T + 1), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
